digit_scan_ctrl: RTL and testbench

- Time-multiplexing scan controller for the 6-digit seven-segment display driven by the operation blocks. Each operation block emits six 4-bit digit codes, d1 (leftmost) to d6 (rightmost).
- Captures a digit set on a load strobe and holds it in a pending buffer. The pending set is committed at a frame boundary, so no tearing occurs.
- Cycles one digit per refresh tick, driving the active-low digit select and the 4-bit code that feeds the segment decoder.

---
 rtl/digit_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_digit_scan_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/digit_scan_ctrl.sv
// rtl/digit_scan_ctrl.sv - six-digit seven-segment scan controller with frame-aligned digit commit
// Optional leading-zero suppression: define DIGIT_SCAN_ZERO_BLANK_EN.
module digit_scan_ctrl #(
    parameter int DIV   = 50000,
    parameter int DIV_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       load_req,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] d4,
    input  logic [3:0] d5,
    input  logic [3:0] d6,
    output logic       load_ack,
    output logic       pending,
    output logic [5:0] seg_sel,
    output logic [3:0] digit_out,
    output logic       frame_start
);

    typedef enum logic {BLANK, SCAN} state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] presc, presc_n;
    logic [2:0]       idx, idx_n;
    logic [5:0][3:0]  din;
    logic [5:0][3:0]  active, active_n;
    logic [5:0][3:0]  pend_buf;
    logic             pending_n;
    logic             tick, boundary, commit;
    logic [5:0]       seg_sel_d;
    logic [3:0]       digit_out_d;

    // Element 0 is d1 so that idx 0 addresses the leftmost digit.
    assign din = {d6, d5, d4, d3, d2, d1};

    assign tick     = (state == SCAN) && (presc == DIV_W'(DIV - 1));
    assign boundary = en && ((state == BLANK) || (tick && (idx == 3'd5)));
    assign commit   = boundary && (pending || load_req);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BLANK;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            BLANK:   if (en)  state_n = SCAN;
            SCAN:    if (!en) state_n = BLANK;
            default: state_n = BLANK;
        endcase
    end

    always_comb begin
        presc_n = '0;
        idx_n   = 3'd0;
        if (state == SCAN && en) begin
            if (tick) begin
                idx_n = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                presc_n = presc + DIV_W'(1);
                idx_n   = idx;
            end
        end
    end

    // A load on the boundary cycle bypasses the pending buffer entirely.
    always_comb begin
        active_n  = active;
        pending_n = pending;
        if (commit) begin
            active_n  = load_req ? din : pend_buf;
            pending_n = 1'b0;
        end else if (load_req) begin
            pending_n = 1'b1;
        end
    end

`ifdef DIGIT_SCAN_ZERO_BLANK_EN
    logic [5:0] lead_zero;
    logic       run_zero;

    always_comb begin
        lead_zero = '0;
        run_zero  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            run_zero     = run_zero && (active_n[k] == 4'd0);
            lead_zero[k] = run_zero;
        end
    end
`endif

    always_comb begin
        seg_sel_d   = 6'b111111;
        digit_out_d = active_n[idx_n];
        if (state_n == SCAN) begin
            seg_sel_d = ~(6'b100000 >> idx_n);
`ifdef DIGIT_SCAN_ZERO_BLANK_EN
            if (lead_zero[idx_n]) seg_sel_d = 6'b111111;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc       <= '0;
            idx         <= 3'd0;
            active      <= '0;
            pend_buf    <= '0;
            pending     <= 1'b0;
            seg_sel     <= 6'b111111;
            digit_out   <= 4'd0;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            presc       <= presc_n;
            idx         <= idx_n;
            active      <= active_n;
            if (load_req) pend_buf <= din;
            pending     <= pending_n;
            seg_sel     <= seg_sel_d;
            digit_out   <= digit_out_d;
            load_ack    <= commit;
            frame_start <= boundary;
        end
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb/tb_digit_scan_ctrl.sv - randomized and directed bench for digit_scan_ctrl against a frame-position model
module tb_digit_scan_ctrl;

    localparam int DIV   = 4;
    localparam int FRAME = 6 * DIV;

    typedef logic [5:0][3:0] dset_t;

    logic       clk = 1'b0;
    logic       reset, en, load_req;
    logic [3:0] d1, d2, d3, d4, d5, d6;
    logic       load_ack, pending, frame_start;
    logic [5:0] seg_sel;
    logic [3:0] digit_out;

    int n_vec = 0;
    int n_err = 0;

    // Model: position within the frame in clock cycles, plus the two digit sets.
    bit    m_scan;
    int    m_pos;
    dset_t m_active, m_pend;
    bit    m_pending, m_fs, m_ack;

    always #5 clk = ~clk;

    digit_scan_ctrl #(.DIV(DIV), .DIV_W(3)) dut (
        .clk(clk), .reset(reset), .en(en), .load_req(load_req),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6),
        .load_ack(load_ack), .pending(pending), .seg_sel(seg_sel),
        .digit_out(digit_out), .frame_start(frame_start)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit slot_blank(input int k);
        bit z = 1'b0;
`ifdef DIGIT_SCAN_ZERO_BLANK_EN
        z = (k < 5);
        for (int j = 0; j <= k; j++) if (m_active[j] != 4'd0) z = 1'b0;
`endif
        return z;
    endfunction

    task automatic model(input bit r, input bit e, input bit l, input dset_t din);
        bit bnd;
        if (r) begin
            m_scan = 0; m_pos = 0; m_active = '0; m_pend = '0;
            m_pending = 0; m_fs = 0; m_ack = 0;
            return;
        end
        bnd   = e && (!m_scan || m_pos == FRAME - 1);
        m_fs  = bnd;
        m_ack = bnd && (m_pending || l);
        if (m_ack) begin
            m_active  = l ? din : m_pend;
            m_pending = 0;
        end else if (l) begin
            m_pend    = din;
            m_pending = 1;
        end
        if (!e)           begin m_scan = 0; m_pos = 0; end
        else if (!m_scan) begin m_scan = 1; m_pos = 0; end
        else              m_pos = (m_pos + 1) % FRAME;
    endtask

    task automatic step(input bit r, input bit e, input bit l, input dset_t din);
        int         slot;
        logic [5:0] exp_sel;
        reset = r; en = e; load_req = l;
        {d6, d5, d4, d3, d2, d1} = din;
        @(posedge clk);
        model(r, e, l, din);
        #1;
        slot    = m_scan ? m_pos / DIV : 0;
        exp_sel = 6'b111111;
        if (m_scan && !slot_blank(slot)) exp_sel[5 - slot] = 1'b0;
        chk($sformatf("seg_sel@%0t", $time), {2'b0, seg_sel}, {2'b0, exp_sel});
        chk($sformatf("digit_out@%0t", $time), {4'b0, digit_out}, {4'b0, m_active[slot]});
        chk($sformatf("frame_start@%0t", $time), {7'b0, frame_start}, {7'b0, m_fs});
        chk($sformatf("load_ack@%0t", $time), {7'b0, load_ack}, {7'b0, m_ack});
        chk($sformatf("pending@%0t", $time), {7'b0, pending}, {7'b0, m_pending});
    endtask

    task automatic run(input int n, input bit e);
        for (int i = 0; i < n; i++) step(0, e, 0, '0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_seg_sel"}, {2'b0, seg_sel}, 8'h3f);
        chk({tag, "_digit_out"}, {4'b0, digit_out}, 8'h00);
        chk({tag, "_load_ack"}, {7'b0, load_ack}, 8'h00);
        chk({tag, "_frame_start"}, {7'b0, frame_start}, 8'h00);
        chk({tag, "_pending"}, {7'b0, pending}, 8'h00);
    endtask

    initial begin
        int    acks;
        bit    found;
        dset_t ds;

        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        chk_reset_vals("reset");

        // Start scanning; first SCAN cycle carries frame_start and slot 0.
        step(0, 1, 0, '0);
        chk("first_frame_start", {7'b0, frame_start}, 8'h01);
        chk("first_seg_sel", {2'b0, seg_sel}, 8'h1f);
        run(FRAME + 5, 1);

        // Mid-frame load of 1..6, held until the boundary.
        while (m_pos != 2 * DIV) step(0, 1, 0, '0);
        ds = {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        step(0, 1, 1, ds);
        chk("mid_load_pending", {7'b0, pending}, 8'h01);
        run(2 * FRAME, 1);

        // Two loads in one frame: exactly one ack, latest set shown.
        step(0, 1, 1, {4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA});
        run(3, 1);
        step(0, 1, 1, {4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h9});
        acks = 0;
        for (int i = 0; i < FRAME + 2; i++) begin
            step(0, 1, 0, '0);
            if (load_ack) acks++;
        end
        chk("double_load_acks", 8'(acks), 8'd1);

        // Load exactly on the boundary cycle: bypass.
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            if (m_pos == FRAME - 1) found = 1;
            else step(0, 1, 0, '0);
        end
        chk("boundary_found", {7'b0, found}, 8'h01);
        step(0, 1, 1, {4'd7, 4'd0, 4'd8, 4'd0, 4'd9, 4'd3});
        chk("bypass_ack", {7'b0, load_ack}, 8'h01);
        chk("bypass_pending", {7'b0, pending}, 8'h00);
        chk("bypass_slot0", {4'b0, digit_out}, 8'h03);
        run(FRAME, 1);

        // Drop en mid-frame for 10 cycles, load while blank, resume.
        run(7, 1);
        run(5, 0);
        step(0, 0, 1, {4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3});
        run(4, 0);
        chk("blank_seg_sel", {2'b0, seg_sel}, 8'h3f);
        step(0, 1, 0, '0);
        chk("resume_frame_start", {7'b0, frame_start}, 8'h01);
        chk("resume_ack", {7'b0, load_ack}, 8'h01);
        run(FRAME + 3, 1);

        // Leading zeros, then an all-zero set.
        step(0, 1, 1, {4'd7, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0});
        run(2 * FRAME, 1);
        step(0, 1, 1, '0);
        run(2 * FRAME, 1);

        // Randomized traffic including codes above 9 and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            ds = dset_t'({$urandom, $urandom});
            step($urandom_range(0, 199) == 0, $urandom_range(0, 15) != 0,
                 $urandom_range(0, 7) == 0, ds);
        end

        // Reset while mid-frame with a pending set discards everything.
        step(0, 1, 0, '0);
        run(5, 1);
        step(0, 1, 1, {4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5});
        step(1, 1, 0, '0);
        chk_reset_vals("midreset");
        step(0, 1, 0, '0);
        run(FRAME + 2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
